inst_fetch: RTL and testbench
=============================

# inst_fetch

Instruction fetch unit feeding the `ctrl` decoder's `ir` input. It owns the PC, issues sequential word fetches to instruction memory over a valid/ready request channel, and buffers in-order responses in a small FIFO. It presents one instruction at a time to the decode stage with valid/ready, and on a `redirect` (taken jump/branch) flushes everything in flight and restarts at the new PC.

## Interface
- `ADDR_WIDTH`, 32, PC / fetch address width
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `FIFO_DEPTH`, 4, instruction buffer entries; power of two, ≥2; also the max outstanding-plus-buffered count
- `clk` in 1 — single clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `imem_req_valid` out 1 — fetch request valid
- `imem_req_ready` in 1 — memory accepts request
- `imem_req_addr` out ADDR_WIDTH — word-aligned fetch address
- `imem_rsp_valid` in 1 — response data valid; one per accepted request, in order, ≥1 cycle after acceptance, no backpressure
- `imem_rsp_data` in `INST_WIDTH` — fetched instruction
- `ir` out `INST_WIDTH` — instruction to decoder
- `ir_pc` out ADDR_WIDTH — PC of `ir`
- `ir_valid` out 1 — `ir`/`ir_pc` valid
- `ir_ready` in 1 — decoder consumes `ir`
- `redirect` in 1 — flush and restart fetch (jump or taken branch)
- `redirect_pc` in ADDR_WIDTH — restart address
- `fetch_fault` out 1 — misaligned redirect detected (see Configuration)

## Operation
- State: `pc_q` (next request address), `out_cnt` (accepted, unanswered, live requests), `drop_cnt` (stale responses to discard), FIFO of {data, pc}, `occ`.
- Issue: `imem_req_valid = !redirect && !fetch_fault && (out_cnt + occ < FIFO_DEPTH)`. Credit reserves a FIFO slot per outstanding request; FIFO never overflows.
- Accept (`valid && ready`): `out_cnt++`, `pc_q += 4`. `imem_req_addr = pc_q`, stable while valid is high; valid drops only on `redirect`.
- Response with `drop_cnt != 0`: discarded, `drop_cnt--`. Otherwise pushed with its PC (tracked by a response-PC counter advancing +4 per push), `out_cnt--`.
- Output: `ir/ir_pc/ir_valid` from FIFO head; pop on `ir_valid && ir_ready`. Empty: `ir_valid=0`, `ir` = 32'h0000_0013 (NOP).
- Redirect (highest priority, takes effect at the edge): FIFO cleared, `pc_q` and response-PC ← `redirect_pc`, `drop_cnt ← drop_cnt + out_cnt` minus any response arriving that cycle, `out_cnt ← 0`. A response in the redirect cycle is stale and dropped. A pop in the redirect cycle is void.
- Counter widths: `$clog2(FIFO_DEPTH)+1`; `drop_cnt` saturates at FIFO_DEPTH (cannot exceed by construction).
- Simultaneous push and pop when full: legal, occupancy unchanged.

## Timing
- Reset (async assert): `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `ir_valid=0`, `ir=32'h13`, `ir_pc=0`, `fetch_fault=0`, all counters 0, FIFO empty.
- First request asserted in the first cycle after `rst_n` rises.
- Response at edge N → `ir_valid` high after edge N (registered FIFO, 1-cycle response-to-decode latency).
- Redirect asserted in cycle N: no request in cycle N; request to `redirect_pc` in cycle N+1; earliest new `ir_valid` cycle N+3 with 1-cycle memory.
- Zero-wait memory, `ir_ready` tied high: sustained 1 instruction/cycle.
- Reset mid-transfer: all in-flight state lost; memory must also be reset.

## Configuration
- `INST_FETCH_ALIGN_CHECK_EN` defined: redirect with `redirect_pc[1:0] != 0` sets `fetch_fault` (sticky until reset), flushes as normal, and blocks all further requests; pending stale responses still drained.
- Undefined: `fetch_fault` tied 0; `redirect_pc[1:0]` forced to 2'b00.

## Test plan
- Reset, 1-cycle memory, `ir_ready=1` → requests 0x0,0x4,0x8…; `ir_pc` 0x0,0x4,0x8 on consecutive cycles, `ir` matches memory.
- `ir_ready=0` for 10 cycles → exactly FIFO_DEPTH(4) requests accepted, then valid low; release → 4 instructions in order, fetch resumes at 0x10.
- 3-cycle memory latency, redirect to 0x100 with 3 outstanding → 3 responses dropped, next `ir_pc`=0x100 with data from 0x100.
- Redirect coinciding with response and pop in same cycle → that response dropped, no duplicate/skip; next `ir_pc`=redirect target.
- `imem_req_ready` low 5 cycles → `imem_req_addr` stable; `rst_n` pulsed mid-stream → outputs at reset values immediately, restart at RESET_PC.
- With `INST_FETCH_ALIGN_CHECK_EN`, redirect to 0x102 → `fetch_fault=1`, no further requests, `ir_valid=0`; without macro → fetch at 0x100.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, issues credit-limited word fetches and buffers
// in-order responses for the decoder. Define INST_FETCH_ALIGN_CHECK_EN for misaligned-redirect faulting.
module inst_fetch #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 4,
    parameter int                    INST_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    output logic [INST_WIDTH-1:0] ir,
    output logic [ADDR_WIDTH-1:0] ir_pc,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  fetch_fault
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
    logic [CW-1:0]         out_cnt_q, out_cnt_d, drop_cnt_q, drop_cnt_d, occ_q, occ_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                  fault_q, fault_d, misalign;
    logic [CW:0]           credit_sum, drop_sum;
    logic                  accept, push, pop, rsp_drop;

    logic [INST_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem   [FIFO_DEPTH];

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign redir_pc = redirect_pc;
    assign misalign = redirect && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign unused_lsb = ^redirect_pc[1:0];
    assign redir_pc   = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
    assign misalign   = 1'b0;
`endif

    // Each outstanding request holds a FIFO slot, so a response always has room.
    assign credit_sum     = {1'b0, out_cnt_q} + {1'b0, occ_q};
    assign imem_req_valid = rst_n && !redirect && !fault_q && (credit_sum < (CW+1)'(FIFO_DEPTH));
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
    assign push     = imem_rsp_valid && (drop_cnt_q == '0) && !redirect;
    assign ir_valid = (occ_q != '0);
    assign pop      = ir_valid && ir_ready && !redirect;

    assign ir          = ir_valid ? data_mem[rd_ptr_q] : NOP;
    assign ir_pc       = ir_valid ? pc_mem[rd_ptr_q] : '0;
    assign fetch_fault = fault_q;

    // Responses still owed by memory become stale on redirect; the one arriving
    // in the redirect cycle itself is already retired from the count.
    assign drop_sum = {1'b0, drop_cnt_q} + {1'b0, out_cnt_q} - (CW+1)'(imem_rsp_valid);

    always_comb begin
        pc_d       = pc_q;
        rsp_pc_d   = rsp_pc_q;
        out_cnt_d  = out_cnt_q;
        drop_cnt_d = drop_cnt_q;
        occ_d      = occ_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fault_d    = fault_q | misalign;
        if (redirect) begin
            pc_d       = redir_pc;
            rsp_pc_d   = redir_pc;
            out_cnt_d  = '0;
            occ_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_cnt_d = (drop_sum > (CW+1)'(FIFO_DEPTH)) ? CW'(FIFO_DEPTH) : drop_sum[CW-1:0];
        end else begin
            out_cnt_d = out_cnt_q + CW'(accept) - CW'(push);
            occ_d     = occ_q + CW'(push) - CW'(pop);
            wr_ptr_d  = wr_ptr_q + PW'(push);
            rd_ptr_d  = rd_ptr_q + PW'(pop);
            if (accept)   pc_d       = pc_q + ADDR_WIDTH'(4);
            if (push)     rsp_pc_d   = rsp_pc_q + ADDR_WIDTH'(4);
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            occ_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rsp_pc_q   <= rsp_pc_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fault_q    <= fault_d;
        end
    end

    // Storage is qualified by occ_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr_q] <= imem_rsp_data;
            pc_mem[wr_ptr_q]   <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboarded bench for inst_fetch: a latency-programmable memory model answers fetches,
// directed phases push the expected PC stream, and a monitor checks every consumed instruction.
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    inst_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .redirect(redirect), .redirect_pc(redirect_pc),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: fixed latency per request, in-order, one response per accept.
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t       mq[$];
    int          cyc = 0;
    int          lat = 1;
    int          acc_cnt = 0;
    logic        acc_pend = 1'b0, rsp_pend = 1'b0;
    logic [31:0] acc_addr = '0;

    always @(negedge clk) begin
        acc_pend = rst_n && imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp_pend = imem_rsp_valid;
    end

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            mq.delete();
        end else begin
            if (rsp_pend && mq.size() > 0) void'(mq.pop_front());
            if (acc_pend) begin
                mq.push_back('{addr: acc_addr, due: cyc + lat});
                acc_cnt++;
            end
        end
        #1;
        if (rst_n && mq.size() > 0 && mq[0].due == cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(mq[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Scoreboard: expected PCs of consumed instructions.
    logic [31:0] exp_q[$];

    always @(negedge clk) begin
        if (rst_n && ir_valid && ir_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got pc %h, expected none", ir_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("ir_pc", ir_pc, e);
                chk("ir", ir, inst_of(e));
            end
        end
    end

    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    // Caller sits at posedge+1; returns at posedge+1 right after the last pop.
    task automatic drain(input bit hold);
        int t = 0;
        ir_ready = 1'b1;
        while (exp_q.size() != 0 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: got %0d left, expected 0", exp_q.size());
            exp_q.delete();
        end
        if (!hold) ir_ready = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
        @(posedge clk);
        #1;
        redirect = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        ir_ready       = 1'b0;
        redirect       = 1'b0;
        redirect_pc    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_ir", ir, 32'h13);
        chk("rst_ir_pc", ir_pc, 32'h0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        acc_cnt = 0;
        rst_n   = 1'b1;
        #1;
        chk("first_req_valid", 32'(imem_req_valid), 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0);

        // Decoder stalled: only FIFO_DEPTH requests may be accepted.
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("stall_accepts", 32'(acc_cnt), 32'd4);
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_ir_valid", 32'(ir_valid), 32'd1);
        chk("stall_ir_pc", ir_pc, 32'h0);
        @(posedge clk);
        #1;
        push_exp(32'h0, 8);
        drain(1'b0);

        // 3-cycle memory, redirect while requests are outstanding.
        repeat (8) @(posedge clk);
        #1;
        lat = 3;
        do_redirect(32'h200);
        push_exp(32'h200, 8);
        drain(1'b0);
        do_redirect(32'h100);
        push_exp(32'h100, 6);
        drain(1'b0);

        // 1-cycle memory; redirect lands on a cycle with both a response and a pop.
        repeat (10) @(posedge clk);
        #1;
        lat = 1;
        do_redirect(32'h300);
        push_exp(32'h300, 5);
        drain(1'b1);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        push_exp(32'h400, 5);
        #3;
        chk("redir_cycle_ir_valid", 32'(ir_valid), 32'd1);
        chk("redir_cycle_rsp_valid", 32'(imem_rsp_valid), 32'd1);
        chk("redir_cycle_req_valid", 32'(imem_req_valid), 32'd0);
        @(posedge clk);
        #1;
        redirect = 1'b0;
        drain(1'b0);

        // Memory not ready: request address held.
        imem_req_ready = 1'b0;
        do_redirect(32'h500);
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("hold_req_addr", imem_req_addr, 32'h500);
            chk("hold_req_valid", 32'(imem_req_valid), 32'd1);
            @(posedge clk);
            #1;
        end
        imem_req_ready = 1'b1;
        push_exp(32'h500, 4);
        drain(1'b0);

        // Reset pulsed mid-stream.
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_req_addr", imem_req_addr, 32'h0);
        chk("mid_rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("mid_rst_ir", ir, 32'h13);
        chk("mid_rst_ir_pc", ir_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_exp(32'h0, 4);
        drain(1'b0);

        // Misaligned redirect target.
        do_redirect(32'h102);
`ifdef INST_FETCH_ALIGN_CHECK_EN
        ir_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("fault_set", 32'(fetch_fault), 32'd1);
        chk("fault_req_valid", 32'(imem_req_valid), 32'd0);
        chk("fault_ir_valid", 32'(ir_valid), 32'd0);
        ir_ready = 1'b0;
`else
        chk("no_fault", 32'(fetch_fault), 32'd0);
        push_exp(32'h100, 4);
        drain(1'b0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
